// File: rtl/bowling_game_ctrl.sv
// Game sequencer for a bowling lane: captures each throw's pin count and
// replays it as single-cycle hit pulses into the score counter.
module bowling_game_ctrl #(
  parameter int unsigned NUM_THROWS  = 3,
  parameter int unsigned MAX_PINS    = 10,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned TW          = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       new_game,
  input  logic       throw_start,
  input  logic       throw_done,
  input  logic [3:0] pins_down,
  output logic       hit,
  output logic       score_clr,
  output logic [1:0] throw_num,
  output logic       rolling,
  output logic       game_over
);

  localparam int unsigned PW = 4;
  localparam int unsigned NW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLLING,
    S_TALLY,
    S_ADVANCE,
    S_DONE,
    S_CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic          hit_q, hit_d;
  logic          score_clr_q, score_clr_d;
  logic [NW-1:0] throw_num_q, throw_num_d;
  logic          rolling_q, rolling_d;
  logic          game_over_q, game_over_d;
  logic [PW-1:0] pin_cnt_q, pin_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [PW-1:0] pins_clamped_c;
  logic          timeout_c;
  logic          last_throw_c;

  assign pins_clamped_c = (pins_down > PW'(MAX_PINS)) ? PW'(MAX_PINS) : pins_down;
  assign timeout_c      = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign last_throw_c   = (throw_num_q == NW'(NUM_THROWS - 1));

  // Next-state and registered-output logic; new_game overrides everything
  always_comb begin
    state_d     = state_q;
    hit_d       = 1'b0;
    score_clr_d = 1'b0;
    throw_num_d = throw_num_q;
    rolling_d   = rolling_q;
    game_over_d = game_over_q;
    pin_cnt_d   = pin_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;

    if (new_game) begin
      state_d     = S_CLEAR;
      score_clr_d = 1'b1;
      throw_num_d = '0;
      rolling_d   = 1'b0;
      game_over_d = 1'b0;
      pin_cnt_d   = '0;
      tmo_cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (throw_start) begin
            state_d   = S_ROLLING;
            tmo_cnt_d = '0;
            rolling_d = 1'b1;
          end
        end
        S_ROLLING: begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (throw_done) begin
            rolling_d = 1'b0;
            if (pins_clamped_c != '0) begin
              // first hit goes out on the same edge that samples the result
              state_d   = S_TALLY;
              hit_d     = 1'b1;
              pin_cnt_d = pins_clamped_c - PW'(1);
            end else begin
              state_d   = S_ADVANCE;
              pin_cnt_d = '0;
            end
          end else if (timeout_c) begin
            rolling_d = 1'b0;
            pin_cnt_d = '0;
            state_d   = S_ADVANCE;
          end
        end
        S_TALLY: begin
          if (pin_cnt_q != '0) begin
            hit_d     = 1'b1;
            pin_cnt_d = pin_cnt_q - PW'(1);
          end else begin
            state_d = S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (last_throw_c) begin
            state_d     = S_DONE;
            game_over_d = 1'b1;
          end else begin
            throw_num_d = throw_num_q + NW'(1);
            state_d     = S_IDLE;
          end
        end
        S_DONE: begin
          game_over_d = 1'b1;
        end
        S_CLEAR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hit_q       <= 1'b0;
      score_clr_q <= 1'b0;
      throw_num_q <= '0;
      rolling_q   <= 1'b0;
      game_over_q <= 1'b0;
      pin_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      score_clr_q <= score_clr_d;
      throw_num_q <= throw_num_d;
      rolling_q   <= rolling_d;
      game_over_q <= game_over_d;
      pin_cnt_q   <= pin_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign hit       = hit_q;
  assign score_clr = score_clr_q;
  assign throw_num = throw_num_q;
  assign rolling   = rolling_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_bowling_game_ctrl.sv
// Directed bench for bowling_game_ctrl: a throw-level model is compared every
// cycle, plus hand-computed hit/pulse totals per scenario.
module tb_bowling_game_ctrl;

  localparam int unsigned NT = 3;
  localparam int unsigned MP = 10;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;

  logic       CLOCK_50    = 1'b0;
  logic       reset       = 1'b1;
  logic       new_game    = 1'b0;
  logic       throw_start = 1'b0;
  logic       throw_done  = 1'b0;
  logic [3:0] pins_down   = 4'd0;
  logic       hit, score_clr, rolling, game_over;
  logic [1:0] throw_num;

  bowling_game_ctrl #(
    .NUM_THROWS(NT), .MAX_PINS(MP), .TIMEOUT_CYC(TO), .TW(TW)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .new_game(new_game),
    .throw_start(throw_start), .throw_done(throw_done), .pins_down(pins_down),
    .hit(hit), .score_clr(score_clr), .throw_num(throw_num),
    .rolling(rolling), .game_over(game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Throw-level model: phase 0 awaiting ball, 1 ball rolling, 2 settling
  // (hits then a bookkeeping edge), 3 game over.
  int m_phase, m_elapsed, m_hits_left, m_until_adv, m_throw, m_p;
  int m_hits_total = 0;
  bit m_hit, m_clr, m_roll, m_over;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_hits_left = 0; m_until_adv = 0; m_throw = 0;
      m_hit = 0; m_clr = 0; m_roll = 0; m_over = 0;
    end else begin
      m_hit = 0;
      m_clr = 0;
      if (new_game) begin
        m_clr = 1; m_roll = 0; m_over = 0; m_throw = 0; m_phase = 0;
        m_hits_left = 0;
      end else begin
        case (m_phase)
          0: if (throw_start) begin
            m_phase = 1; m_roll = 1; m_elapsed = 0;
          end
          1: if (throw_done) begin
            m_p = (int'(pins_down) > int'(MP)) ? int'(MP) : int'(pins_down);
            m_roll = 0; m_phase = 2; m_until_adv = m_p + 1;
            if (m_p > 0) begin
              m_hit = 1; m_hits_left = m_p - 1;
            end else m_hits_left = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == int'(TO)) begin
              m_roll = 0; m_phase = 2; m_hits_left = 0; m_until_adv = 1;
            end
          end
          2: begin
            if (m_hits_left > 0) begin
              m_hit = 1; m_hits_left--;
            end
            m_until_adv--;
            if (m_until_adv == 0) begin
              if (m_throw == int'(NT) - 1) begin
                m_over = 1; m_phase = 3;
              end else begin
                m_throw++; m_phase = 0;
              end
            end
          end
          default: ;
        endcase
      end
      if (m_hit) m_hits_total++;
    end
  end

  always @(negedge CLOCK_50) begin
    chk("hit", 32'(hit), 32'(m_hit));
    chk("score_clr", 32'(score_clr), 32'(m_clr));
    chk("throw_num", 32'(throw_num), 32'(m_throw));
    chk("rolling", 32'(rolling), 32'(m_roll));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("hit_clr_excl", 32'(hit & score_clr), 32'd0);
  end

  int n_hit = 0, n_clr = 0, n_roll = 0;
  always @(posedge CLOCK_50) begin
    #1;
    if (hit === 1'b1) n_hit++;
    if (score_clr === 1'b1) n_clr++;
    if (rolling === 1'b1) n_roll++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse(input bit s, input bit d, input bit ng, input logic [3:0] p);
    throw_start = s; throw_done = d; new_game = ng; pins_down = p;
    @(negedge CLOCK_50);
    throw_start = 0; throw_done = 0; new_game = 0; pins_down = 4'd0;
  endtask

  task automatic throw_pins(input logic [3:0] p);
    pulse(1, 0, 0, 4'd0);
    idle(2);
    pulse(0, 1, 0, p);
    idle(int'(MP) + 4);
  endtask

  int h0, c0, r0;

  initial begin
    idle(2);
    reset = 0;
    idle(1);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_clr", 32'(score_clr), 0);
    chk("rst_throw", 32'(throw_num), 0);
    chk("rst_rolling", 32'(rolling), 0);
    chk("rst_over", 32'(game_over), 0);

    // 7 pins
    h0 = n_hit;
    throw_pins(4'd7);
    chk("p7_hits", 32'(n_hit - h0), 7);
    chk("p7_throw", 32'(throw_num), 1);
    chk("p7_rolling", 32'(rolling), 0);

    // throw_done in IDLE ignored; start+done together only starts; 15 clamps
    h0 = n_hit;
    pulse(0, 1, 0, 4'd5);
    idle(3);
    pulse(1, 1, 0, 4'd5);
    idle(2);
    chk("simul_rolling", 32'(rolling), 1);
    chk("simul_hits", 32'(n_hit - h0), 0);
    pulse(0, 1, 0, 4'd15);
    idle(14);
    chk("p15_hits", 32'(n_hit - h0), 10);
    chk("p15_throw", 32'(throw_num), 2);

    // 0 pins on last throw ends game; later throws ignored
    h0 = n_hit;
    throw_pins(4'd0);
    chk("p0_hits", 32'(n_hit - h0), 0);
    chk("p0_over", 32'(game_over), 1);
    chk("p0_throw", 32'(throw_num), 2);
    pulse(1, 0, 0, 4'd0);
    idle(3);
    chk("over_rolling", 32'(rolling), 0);
    pulse(0, 1, 0, 4'd10);
    idle(12);
    chk("over_hits", 32'(n_hit - h0), 0);
    chk("over_hold", 32'(game_over), 1);

    // new game, then strike x3
    c0 = n_clr;
    pulse(0, 0, 1, 4'd0);
    idle(2);
    chk("ng_clr", 32'(n_clr - c0), 1);
    chk("ng_throw", 32'(throw_num), 0);
    chk("ng_over", 32'(game_over), 0);
    h0 = n_hit;
    throw_pins(4'd10);
    throw_pins(4'd10);
    throw_pins(4'd10);
    chk("x3_hits", 32'(n_hit - h0), 30);
    chk("x3_over", 32'(game_over), 1);

    // timeout with no result
    pulse(0, 0, 1, 4'd0);
    idle(2);
    h0 = n_hit; r0 = n_roll;
    pulse(1, 0, 0, 4'd0);
    idle(int'(TO) + 4);
    chk("to_roll_cycles", 32'(n_roll - r0), 8);
    chk("to_hits", 32'(n_hit - h0), 0);
    chk("to_throw", 32'(throw_num), 1);

    // result arriving on the timeout cycle wins
    h0 = n_hit;
    pulse(1, 0, 0, 4'd0);
    idle(int'(TO) - 1);
    pulse(0, 1, 0, 4'd3);
    idle(8);
    chk("to_edge_hits", 32'(n_hit - h0), 3);
    chk("to_edge_throw", 32'(throw_num), 2);

    // new_game truncates a 9-pin burst after 4 hits
    pulse(0, 0, 1, 4'd0);
    idle(1);
    h0 = n_hit; c0 = n_clr;
    pulse(1, 0, 0, 4'd0);
    idle(2);
    pulse(0, 1, 0, 4'd9);
    idle(3);
    pulse(0, 0, 1, 4'd0);
    idle(12);
    chk("trunc_hits", 32'(n_hit - h0), 4);
    chk("trunc_clr", 32'(n_clr - c0), 1);
    chk("trunc_throw", 32'(throw_num), 0);
    chk("trunc_over", 32'(game_over), 0);
    h0 = n_hit;
    throw_pins(4'd2);
    chk("after_trunc_hits", 32'(n_hit - h0), 2);

    // async reset mid-burst
    h0 = n_hit;
    pulse(1, 0, 0, 4'd0);
    idle(2);
    pulse(0, 1, 0, 4'd5);
    idle(1);
    #2 reset = 1;
    #1;
    chk("arst_hit", 32'(hit), 0);
    chk("arst_clr", 32'(score_clr), 0);
    chk("arst_throw", 32'(throw_num), 0);
    chk("arst_rolling", 32'(rolling), 0);
    chk("arst_over", 32'(game_over), 0);
    @(negedge CLOCK_50);
    reset = 0;
    idle(10);
    chk("arst_hits", 32'(n_hit - h0), 2);
    chk("arst_throw_after", 32'(throw_num), 0);

    chk("model_total", 32'(m_hits_total), 58);
    chk("dut_total", 32'(n_hit), 58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bowling_game_ctrl.md
Name: bowling_game_ctrl

Overview:
- Sequences one bowling game of NUM_THROWS throws and drives the score counter.
- Waits for a throw, captures the pin count reported by the pin-detection logic, and converts it into a burst of single-cycle hit pulses.
- Each hit pulse increments the score counter by one; score_clr clears the counter for a new game.
- Sits between the motion/pin-detect front end and the score counter / HEX display path.

Parameters:
- NUM_THROWS, 3, throws per game (1..3; throw_num is 2 bits).
- MAX_PINS, 10, pins per throw; larger pins_down values are clamped to this.
- TIMEOUT_CYC, 50000000, cycles allowed in ROLLING (1 s at 50 MHz); simulation overrides it small.
- TW, 26, timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  sync pulse; abort and restart the game.
- throw_start  in  1  sync pulse; the ball has been released.
- throw_done  in  1  sync pulse; pins_down is valid this cycle.
- pins_down  in  4  pins knocked down by this throw.
- hit  out  1  one-cycle increment pulse to the score counter.
- score_clr  out  1  one-cycle clear pulse to the score counter.
- throw_num  out  2  current throw index, 0-based.
- rolling  out  1  high while waiting for the throw result.
- game_over  out  1  high after the last throw has been tallied.

Behaviour:
- All outputs are registered.
- Reset (async): state=IDLE; hit=0, score_clr=0, throw_num=0, rolling=0, game_over=0; pin and timeout counters = 0. Reset mid-burst drops the remaining hits.
- States:
  - IDLE: wait for throw_start.
  - ROLLING: wait for throw_done or timeout.
  - TALLY: emit the hit burst.
  - ADVANCE: move to the next throw or end the game.
  - DONE: game over.
  - CLEAR: clear the score and restart.
- IDLE -> ROLLING on throw_start. Timeout counter loads 0; rolling=1 from the next cycle.
- ROLLING:
  - Timeout counter increments each cycle.
  - throw_done: latch p = min(pins_down, MAX_PINS). Go to TALLY if p>0, else ADVANCE.
  - Counter reaching TIMEOUT_CYC-1 with no throw_done: p=0, go to ADVANCE.
  - throw_done in the same cycle as the timeout: throw_done wins.
  - rolling=0 once ROLLING is left.
- TALLY:
  - hit=1 on exactly p consecutive cycles.
  - First hit is the cycle after the throw_done sample edge; remaining count decrements per hit.
  - After the last hit go to ADVANCE.
  - Latency from throw_done to the final hit = p cycles.
- ADVANCE (1 cycle):
  - If throw_num == NUM_THROWS-1: go to DONE, game_over=1, throw_num holds.
  - Else: throw_num+1, go to IDLE.
- DONE: hold game_over=1. Ignore throw_start and throw_done.
- new_game in any state:
  - Go to CLEAR the next cycle. This overrides every other transition in that cycle and truncates any hit burst (no further hits).
  - CLEAR lasts 1 cycle: score_clr=1, throw_num=0, game_over=0, rolling=0. Then go to IDLE.
  - hit and score_clr are never high together.
- Ignore conditions:
  - throw_start outside IDLE is ignored.
  - throw_done outside ROLLING is ignored (pins_down discarded).
  - throw_start and throw_done in the same cycle in IDLE: only throw_start acts.
- Score bound: total hits per game ≤ NUM_THROWS*MAX_PINS = 30, which fits the 5-bit score counter.

Test Plan:
- Reset, then throw_start; throw_done with pins_down=7 -> hit high exactly 7 consecutive cycles starting the next cycle; throw_num 0->1; rolling 1->0.
- Three throws with pins 10, 10, 10 -> 30 hit cycles in total; game_over=1 after the third ADVANCE; a further throw_start is ignored (no hits, rolling stays 0).
- pins_down=15 -> exactly 10 hits. pins_down=0 -> no hits; throw_num still advances.
- TIMEOUT_CYC=8; throw_start with no throw_done -> rolling high for 8 cycles, 0 hits, throw_num advances. throw_done on the timeout cycle with pins_down=3 -> 3 hits.
- new_game after the 4th hit of a 9-pin burst -> hits stop after 4; score_clr pulses once; throw_num=0; game_over=0; state IDLE.
- Assert reset asynchronously mid-TALLY between clock edges -> all outputs 0 immediately; no further hits after release.
